// File: rtl/jpeg_stream_framer.sv
// JPEG framer: header ROM bytes, entropy-coded data (optional 0xFF->0xFF00 stuffing via JPEG_STREAM_FRAMER_STUFF_EN), then EOI 0xFFD9.
// Latency: first header byte is valid two cycles after frame_start; data bytes take one cycle from in to out.
// Backpressure: a single output register stalls on !out_ready, and in_ready follows it combinationally.
module jpeg_stream_framer #(
  parameter int HEADER_LEN = 328,
  parameter int HDR_ADDR_W = 9
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic                  frame_start,
  input  logic                  frame_end,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic [HDR_ADDR_W-1:0] hdr_addr,
  input  logic [7:0]            hdr_data,
  output logic                  out_valid,
  output logic [7:0]            out_data,
  input  logic                  out_ready,
  output logic                  frame_done,
  output logic [23:0]           out_count,
  output logic                  frame_overrun
);

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    DATA,
`ifdef JPEG_STREAM_FRAMER_STUFF_EN
    STUFF,
`endif
    EOI_FF,
    EOI_D9
  } state_t;

  localparam logic [HDR_ADDR_W-1:0] HDR_LAST = HDR_ADDR_W'(HEADER_LEN - 1);

  state_t                state;
  logic [HDR_ADDR_W-1:0] addr_q;
  logic                  hdr_vld;
  logic                  hdr_done;
  logic                  eoi_pend;
  logic                  out_free;
  logic                  out_xfer;
  logic                  hdr_load;
  logic                  in_acc;
  logic                  in_data_phase;

  assign out_free = !out_valid || out_ready;
  assign out_xfer = out_valid && out_ready;
  assign hdr_load = (state == HEADER) && hdr_vld && !hdr_done && out_free;

  // The ROM address runs one byte ahead of out_data so that the header streams without gaps.
  assign hdr_addr = (hdr_load && (addr_q != HDR_LAST)) ? addr_q + 1'b1 : addr_q;

  assign in_ready = (state == DATA) && !eoi_pend && out_free;
  assign in_acc   = in_valid && in_ready;

`ifdef JPEG_STREAM_FRAMER_STUFF_EN
  assign in_data_phase = (state == DATA) || (state == STUFF);
`else
  assign in_data_phase = (state == DATA);
`endif

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state         <= IDLE;
      addr_q        <= '0;
      hdr_vld       <= 1'b0;
      hdr_done      <= 1'b0;
      eoi_pend      <= 1'b0;
      out_valid     <= 1'b0;
      out_data      <= 8'h00;
      frame_done    <= 1'b0;
      out_count     <= 24'd0;
      frame_overrun <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      addr_q     <= hdr_addr;
      if (out_xfer && (out_count != 24'hFFFFFF))
        out_count <= out_count + 24'd1;
      if (frame_start && (state != IDLE))
        frame_overrun <= 1'b1;
      if (frame_end && in_data_phase)
        eoi_pend <= 1'b1;

      case (state)
        IDLE: begin
          if (frame_start) begin
            state     <= HEADER;
            addr_q    <= '0;
            hdr_vld   <= 1'b0;
            hdr_done  <= 1'b0;
            eoi_pend  <= 1'b0;
            out_count <= 24'd0;
          end
        end

        HEADER: begin
          hdr_vld <= 1'b1;
          if (hdr_load) begin
            out_data  <= hdr_data;
            out_valid <= 1'b1;
            if (addr_q == HDR_LAST)
              hdr_done <= 1'b1;
          end else if (out_xfer) begin
            out_valid <= 1'b0;
            if (hdr_done)
              state <= DATA;
          end
        end

        DATA: begin
          if (in_acc) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
`ifdef JPEG_STREAM_FRAMER_STUFF_EN
            if (in_data == 8'hFF)
              state <= STUFF;
`endif
          end else if (eoi_pend && out_free) begin
            out_data  <= 8'hFF;
            out_valid <= 1'b1;
            state     <= EOI_FF;
          end else if (out_xfer) begin
            out_valid <= 1'b0;
          end
        end

`ifdef JPEG_STREAM_FRAMER_STUFF_EN
        STUFF: begin
          // out_valid is high here, so out_free means the 0xFF is transferring now.
          if (out_free) begin
            out_data  <= 8'h00;
            out_valid <= 1'b1;
            state     <= DATA;
          end
        end
`endif

        EOI_FF: begin
          if (out_xfer)begin
            out_data <= 8'hD9;
            state    <= EOI_D9;
          end
        end

        EOI_D9: begin
          if (out_xfer) begin
            out_valid  <= 1'b0;
            frame_done <= 1'b1;
            eoi_pend   <= 1'b0;
            addr_q     <= '0;
            state      <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jpeg_stream_framer.sv
// Randomized scoreboard bench for jpeg_stream_framer with a 4-byte header ROM.
module tb_jpeg_stream_framer;

  localparam int HL = 4;
  localparam int AW = 9;

  logic          clock = 1'b0;
  logic          nreset = 1'b0;
  logic          frame_start = 1'b0;
  logic          frame_end = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready;
  logic [AW-1:0] hdr_addr;
  logic [7:0]    hdr_data;
  logic          out_valid;
  logic [7:0]    out_data;
  logic          out_ready = 1'b1;
  logic          frame_done;
  logic [23:0]   out_count;
  logic          frame_overrun;

  jpeg_stream_framer #(.HEADER_LEN(HL), .HDR_ADDR_W(AW)) dut (
    .clock(clock), .nreset(nreset), .frame_start(frame_start), .frame_end(frame_end),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .hdr_addr(hdr_addr), .hdr_data(hdr_data),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .frame_done(frame_done), .out_count(out_count), .frame_overrun(frame_overrun)
  );

  always #5 clock = ~clock;

  logic [7:0] rom [0:511];
  always @(posedge clock) hdr_data <= rom[hdr_addr];

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int frames_exp = 0;
  int ready_mode = 0;
  logic [7:0] exp_q [$];
  logic [7:0] cur_data [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s (bound expired or unexpected event) at %0t", name, $time);
  endtask

  // out_ready pattern: 0 = always high, 1 = toggle each cycle, 2 = random
  initial begin
    forever begin
      @(posedge clock);
      #1;
      case (ready_mode)
        1:       out_ready = ~out_ready;
        2:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every transfer, checks stall stability and frame_done placement.
  logic       stalled = 1'b0;
  logic [7:0] held = 8'h00;
  logic       prev_d9 = 1'b0;
  always @(negedge clock) begin
    if (!nreset) begin
      stalled = 1'b0;
      prev_d9 = 1'b0;
    end else begin
      if (stalled) check("stall_hold", {23'd0, out_valid, out_data}, {23'd0, 1'b1, held});
      if (frame_done) begin
        check("done_after_d9", {31'd0, prev_d9}, 32'd1);
        done_cnt++;
      end
      prev_d9 = 1'b0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) fail_now("unexpected_byte");
        else check("out_byte", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
        prev_d9 = (out_data == 8'hD9);
      end
      stalled = out_valid && !out_ready;
      held    = out_data;
    end
  end

  task automatic start_frame();
    @(negedge clock);
    frame_start = 1'b1;
    @(posedge clock);
    #1 frame_start = 1'b0;
    @(negedge clock);
    check("hdr_addr_start", {23'd0, hdr_addr}, 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] d, input bit fe, input bit inject);
    int  n;
    bit  done;
    n = 0;
    done = 0;
    while (!done) begin
      @(negedge clock);
      in_valid = 1'b1;
      in_data  = d;
      if (in_ready) begin
        frame_end   = fe;
        frame_start = inject;
        done = 1;
        @(posedge clock);
      end else if (++n > 300) begin
        fail_now("in_ready_timeout");
        done = 1;
      end
    end
    #1;
    in_valid    = 1'b0;
    frame_end   = 1'b0;
    frame_start = 1'b0;
    if (fe) begin
      @(negedge clock);
      check("in_ready_after_end", {31'd0, in_ready}, 32'd0);
    end
  endtask

  task automatic run_frame(input int mode, input bit fe_last, input bit inject);
    int  n_exp;
    int  n;
    bit  seen;
    ready_mode = mode;
    n_exp = 0;
    for (int i = 0; i < HL; i++) begin exp_q.push_back(rom[i]); n_exp++; end
    foreach (cur_data[i]) begin
      exp_q.push_back(cur_data[i]);
      n_exp++;
`ifdef JPEG_STREAM_FRAMER_STUFF_EN
      if (cur_data[i] == 8'hFF) begin exp_q.push_back(8'h00); n_exp++; end
`endif
    end
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hD9);
    n_exp += 2;
    frames_exp++;
    start_frame();
    foreach (cur_data[i]) begin
      repeat ($urandom_range(0, 2)) @(posedge clock);
      send_byte(cur_data[i], fe_last && (i == cur_data.size() - 1), inject && (i == 0));
    end
    if (!fe_last) begin
      repeat ($urandom_range(0, 3)) @(posedge clock);
      @(negedge clock);
      frame_end = 1'b1;
      @(posedge clock);
      #1 frame_end = 1'b0;
    end
    n = 0;
    seen = 0;
    while (!seen && n < 500) begin
      @(negedge clock);
      if (frame_done) seen = 1;
      n++;
    end
    if (!seen) fail_now("frame_done_timeout");
    else begin
      check("out_count", {8'd0, out_count}, n_exp);
      @(negedge clock);
      check("frame_done_pulse", {31'd0, frame_done}, 32'd0);
    end
    repeat (2) @(negedge clock);
    check("frame_done_count", done_cnt, frames_exp);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  task automatic set_hdr(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
    rom[0] = b0; rom[1] = b1; rom[2] = b2; rom[3] = b3;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) rom[i] = 8'h00;
    set_hdr(8'hFF, 8'hD8, 8'hFF, 8'hE0);
    repeat (3) @(posedge clock);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_hdr_addr", {23'd0, hdr_addr}, 32'd0);
    check("rst_out_count", {8'd0, out_count}, 32'd0);
    check("rst_overrun", {31'd0, frame_overrun}, 32'd0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    nreset = 1'b1;
    repeat (2) @(posedge clock);

    // Basic frame, full throughput
    cur_data = '{8'h12, 8'h34};
    run_frame(0, 1, 0);
    // Stuffing candidate in the middle
    cur_data = '{8'hAB, 8'hFF, 8'hCD};
    run_frame(0, 1, 0);
    // Toggled out_ready over header and data
    cur_data = '{8'h12, 8'h34};
    run_frame(1, 1, 0);
    // frame_end on the same beat as an accepted 0xFF
    cur_data = '{8'hFF};
    run_frame(0, 1, 0);
    // frame_start while streaming data
    check("overrun_before", {31'd0, frame_overrun}, 32'd0);
    cur_data = '{8'h55, 8'h66, 8'h77};
    run_frame(2, 1, 1);
    check("overrun_sticky", {31'd0, frame_overrun}, 32'd1);

    // Reset in the middle of the header
    ready_mode = 0;
    start_frame();
    repeat (2) @(posedge clock);
    #1 nreset = 1'b0;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_hdr_addr", {23'd0, hdr_addr}, 32'd0);
    check("midrst_overrun", {31'd0, frame_overrun}, 32'd0);
    check("midrst_out_count", {8'd0, out_count}, 32'd0);
    repeat (2) @(posedge clock);
    #1 nreset = 1'b1;
    done_cnt = 0;
    frames_exp = 0;
    cur_data = '{8'h9A, 8'hBC};
    run_frame(0, 1, 0);

    // Random frames with random headers, backpressure and frame_end placement
    for (int f = 0; f < 14; f++) begin
      set_hdr(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      cur_data.delete();
      for (int k = 0; k < int'($urandom_range(1, 8)); k++)
        cur_data.push_back(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
      run_frame(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
